// File: rtl/ex_stage.sv
// Execute stage: ID->EX pipeline register, single-cycle ALU, data SRAM request,
// EX->MEM bus packing and a sequential restoring divider that owns HI/LO.
module ex_stage #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [31:0] id_pc,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_src1,
    input  logic [31:0] id_src2,
    input  logic [31:0] id_store_data,
    input  logic        id_rf_we,
    input  logic [4:0]  id_rf_waddr,
    input  logic        id_data_ram_en,
    input  logic [3:0]  id_data_ram_wen,
    input  logic        id_sel_rf_res,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [75:0] ex_to_mem_bus,
    output logic        stallreq_for_ex,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_LUI  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_MFHI = 4'd13;
    localparam logic [3:0] OP_MFLO = 4'd14;

    // ID->EX pipeline register fields
    logic [31:0] pc_q, pc_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] sd_q, sd_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic        ram_en_q, ram_en_d;
    logic [3:0]  ram_wen_q, ram_wen_d;
    logic        sel_q, sel_d;

    // Divider state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        is_div;
    logic        div_signed;
    logic        src1_neg;
    logic        src2_neg;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic [31:0] alu_res;
    logic        unused_stall;

    assign unused_stall = ^{stall[5:4], stall[1:0]};

    assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign div_signed = (op_q == OP_DIV);
    assign src1_neg   = div_signed & src1_q[31];
    assign src2_neg   = div_signed & src2_q[31];
    assign rem_sh     = {rem_q, quo_q[31]};
    assign rem_diff   = rem_sh - {1'b0, dvs_q};

    // Pipeline register next value: flush, bubble, capture or hold
    always_comb begin
        pc_d       = pc_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        sd_d       = sd_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        ram_en_d   = ram_en_q;
        ram_wen_d  = ram_wen_q;
        sel_d      = sel_q;
        if (flush || (stall[2] && !stall[3])) begin
            pc_d       = '0;
            op_d       = '0;
            src1_d     = '0;
            src2_d     = '0;
            sd_d       = '0;
            rf_we_d    = 1'b0;
            rf_waddr_d = '0;
            ram_en_d   = 1'b0;
            ram_wen_d  = '0;
            sel_d      = 1'b0;
        end else if (!stall[2]) begin
            pc_d       = id_pc;
            op_d       = id_alu_op;
            src1_d     = id_src1;
            src2_d     = id_src2;
            sd_d       = id_store_data;
            rf_we_d    = id_rf_we;
            rf_waddr_d = id_rf_waddr;
            ram_en_d   = id_data_ram_en;
            ram_wen_d  = id_data_ram_wen;
            sel_d      = id_sel_rf_res;
        end
    end

    // Pipeline register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            sd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            ram_en_q   <= 1'b0;
            ram_wen_q  <= '0;
            sel_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            sd_q       <= sd_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            ram_en_q   <= ram_en_d;
            ram_wen_q  <= ram_wen_d;
            sel_q      <= sel_d;
        end
    end

    // Divider next state: operand capture, restoring steps, sign fix-up into HI/LO
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_div) begin
                        quo_d     = src1_neg ? -src1_q : src1_q;
                        dvs_d     = src2_neg ? -src2_q : src2_q;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = src1_neg ^ src2_neg;
                        neg_rem_d = src1_neg;
                        dz_d      = (src2_q == 32'h0);
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!rem_diff[32]) begin
                        rem_d = rem_diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    lo_d    = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
                    hi_d    = neg_rem_q ? -rem_q : rem_q;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Divider and HI/LO storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Single-cycle ALU on the registered operands
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = src1_q + src2_q;
            OP_SUB:  alu_res = src1_q - src2_q;
            OP_AND:  alu_res = src1_q & src2_q;
            OP_OR:   alu_res = src1_q | src2_q;
            OP_XOR:  alu_res = src1_q ^ src2_q;
            OP_SLL:  alu_res = src2_q << src1_q[4:0];
            OP_SRL:  alu_res = src2_q >> src1_q[4:0];
            OP_SRA:  alu_res = $signed(src2_q) >>> src1_q[4:0];
            OP_SLT:  alu_res = {31'h0, $signed(src1_q) < $signed(src2_q)};
            OP_SLTU: alu_res = {31'h0, src1_q < src2_q};
            OP_LUI:  alu_res = {src2_q[15:0], 16'h0};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign data_sram_en    = ram_en_q;
    assign data_sram_wen   = ram_wen_q;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = sd_q;
    assign ex_to_mem_bus   = {pc_q, ram_en_q, ram_wen_q, sel_q, rf_we_q, rf_waddr_q, alu_res};
    assign stallreq_for_ex = is_div && (state_q != S_DONE);
    assign hi_o            = hi_q;
    assign lo_o            = lo_q;

endmodule
